uart_rx_frame: RTL and testbench

UART_RX_FRAME -- requirements
Module: uart_rx_frame

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_hold.sv | 45 ++++
 rtl/uart_rx_frame.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_frame.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive frame path: FSM state encoding,
// default inter-sample timeout and the legal data-width range.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam int DEF_TIMEOUT_CYC = 6000;
  localparam int DATA_BITS_MIN   = 5;
  localparam int DATA_BITS_MAX   = 8;

endpackage

// File: rtl/uart_rx_hold.sv
// Output holding register for received bytes with overrun detection.
//
// Handshake: rx_valid/rx_ready follow strict valid/ready semantics. A byte is
// transferred on every rising edge where rx_valid and rx_ready are both high.
// While rx_valid is high and rx_ready is low, rx_data is frozen. A new byte
// (load) is accepted when the register is empty or is being drained on the
// same edge; otherwise the new byte is dropped and overrun pulses for one cycle.
module uart_rx_hold
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] load_data,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 overrun
);

  logic can_load;

  assign can_load = !rx_valid || rx_ready;

  // Hold register: load on free slot, clear on drain, flag dropped bytes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load && can_load) begin
        rx_data  <= load_data;
        rx_valid <= 1'b1;
      end else begin
        if (rx_valid && rx_ready) rx_valid <= 1'b0;
        if (load)                 overrun  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: turns voted bit samples from the bit sampler into
// bytes, with start-glitch rejection, stop-bit checking and an inter-sample
// timeout. Optional parity checking is compiled in when the macro
// UART_RX_PARITY_EN is defined; without it the PARITY state is never entered
// and parity_err is tied low. The current FSM state is exported on dbg_state.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int PARITY_ODD  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_flag,
  input  logic                 samp_valid,
  input  logic                 samp_bit,
  output logic                 bps_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output rx_state_t            dbg_state
);

  localparam int CNT_W = $clog2(DATA_BITS_MAX);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  // Reject unsupported configurations at elaboration.
  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
      PARITY_ODD < 0 || PARITY_ODD > 1 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("uart_rx_frame: unsupported parameter value");
  end

  rx_state_t            state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [TMO_W-1:0]     tmo_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 timeout;
  logic                 deliver;

  assign dbg_state = state;

  // A timeout only fires when no sample arrives on the expiring cycle.
  assign timeout = (state != ST_IDLE) && !samp_valid && (tmo_cnt == TMO_LAST);

`ifdef UART_RX_PARITY_EN
  logic perr;
  logic exp_par;

  // Even parity: parity bit equals XOR of data; odd parity: its inverse.
  assign exp_par = (^shreg) ^ (PARITY_ODD != 0);
  assign deliver = (state == ST_STOP) && samp_valid && samp_bit && !perr;
`else
  assign deliver = (state == ST_STOP) && samp_valid && samp_bit;
  assign parity_err = 1'b0;
`endif

  // Frame FSM with registered bps_en and error pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
      shreg     <= '0;
      bps_en    <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr       <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (state == ST_IDLE || samp_valid) tmo_cnt <= '0;
      else                                tmo_cnt <= tmo_cnt + 1'b1;

      if (timeout) begin
        state     <= ST_IDLE;
        bps_en    <= 1'b0;
        frame_err <= 1'b1;
        tmo_cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_flag) begin
              state  <= ST_START;
              bps_en <= 1'b1;
            end
          end
          ST_START: begin
            if (samp_valid) begin
              if (samp_bit) begin
                state  <= ST_IDLE;
                bps_en <= 1'b0;
              end else begin
                state   <= ST_DATA;
                bit_cnt <= '0;
              end
            end
          end
          ST_DATA: begin
            if (samp_valid) begin
              shreg <= {samp_bit, shreg[DATA_BITS-1:1]};
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                state   <= ST_PARITY;
`else
                state   <= ST_STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            if (samp_valid) begin
              perr  <= (samp_bit != exp_par);
              state <= ST_STOP;
            end
          end
`endif
          ST_STOP: begin
            if (samp_valid) begin
              state  <= ST_IDLE;
              bps_en <= 1'b0;
              if (!samp_bit) begin
                frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
              end else if (perr) begin
                parity_err <= 1'b1;
`endif
              end
            end
          end
          default: begin
            state  <= ST_IDLE;
            bps_en <= 1'b0;
          end
        endcase
      end
    end
  end

  uart_rx_hold #(
    .DATA_BITS (DATA_BITS)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (deliver),
    .load_data (shreg),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame. Parity scenarios are included when
// UART_RX_PARITY_EN is defined.
module tb_uart_rx_frame;
  import uart_pkg::*;

  localparam int DW     = 8;
  localparam int TMO    = 6000;
  localparam bit PAR_ODD = 1'b0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_flag;
  logic          samp_valid;
  logic          samp_bit;
  logic          bps_en;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;
  rx_state_t     dbg_state;

  int total = 0;
  int bad   = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  int ov_cnt = 0;
  logic [DW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  uart_rx_frame #(
    .DATA_BITS   (DW),
    .TIMEOUT_CYC (TMO),
    .PARITY_ODD  (int'(PAR_ODD))
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_flag (start_flag),
    .samp_valid (samp_valid),
    .samp_bit   (samp_bit),
    .bps_en     (bps_en),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .dbg_state  (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) step();
  endtask

  // Returns 1 time unit after the edge that sampled the bit.
  task automatic send_bit(input logic b);
    samp_valid = 1'b1;
    samp_bit   = b;
    step();
    samp_valid = 1'b0;
    samp_bit   = 1'b1;
  endtask

  task automatic pulse_start();
    start_flag = 1'b1;
    step();
    start_flag = 1'b0;
  endtask

  task automatic send_data_bits(input logic [DW-1:0] d);
    for (int i = 0; i < DW; i++) begin
      send_bit(d[i]);
      gap(2);
    end
  endtask

  // Start flag, start bit and data bits.
  task automatic send_head(input logic [DW-1:0] d);
    pulse_start();
    send_bit(1'b0);
    gap(2);
    send_data_bits(d);
  endtask

  // Full frame with correct parity (when compiled in); ends right after stop edge.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop);
    send_head(d);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ PAR_ODD);
    gap(2);
`endif
    send_bit(stop);
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (frame_err)  fe_cnt++;
      if (parity_err) pe_cnt++;
      if (overrun)    ov_cnt++;
      if (rx_valid && rx_ready) begin
        check("sb_byte_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("sb_rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int fe0, pe0, ov0;
    logic [DW-1:0] rd;
    bit fired;

    rst_n = 1'b0; start_flag = 1'b0; samp_valid = 1'b0; samp_bit = 1'b1; rx_ready = 1'b1;
    gap(3);
    check("rst_bps_en", 32'(bps_en), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_parity_err", 32'(parity_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    gap(2);

    // samp_valid while idle is ignored
    send_bit(1'b0);
    check("idle_samp_state", 32'(dbg_state), 32'(ST_IDLE));
    check("idle_samp_bps", 32'(bps_en), 0);
    gap(2);

    // 0xA5 with rx_ready high
    exp_q.push_back(8'hA5);
    pulse_start();
    check("a5_bps_start", 32'(bps_en), 1);
    check("a5_state_start", 32'(dbg_state), 32'(ST_START));
    send_bit(1'b0);
    gap(2);
    send_data_bits(8'hA5);
`ifdef UART_RX_PARITY_EN
    send_bit(^8'hA5 ^ PAR_ODD);
    gap(2);
`endif
    check("a5_no_early_valid", 32'(rx_valid), 0);
    send_bit(1'b1);
    check("a5_valid_lat1", 32'(rx_valid), 1);
    check("a5_data", 32'(rx_data), 32'h A5);
    check("a5_bps_off", 32'(bps_en), 0);
    gap(2);
    check("a5_drained", 32'(rx_valid), 0);

    // start glitch
    fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
    pulse_start();
    check("glitch_bps_on", 32'(bps_en), 1);
    send_bit(1'b1);
    check("glitch_state", 32'(dbg_state), 32'(ST_IDLE));
    check("glitch_bps_off", 32'(bps_en), 0);
    gap(3);
    check("glitch_no_valid", 32'(rx_valid), 0);
    check("glitch_no_errs", 32'((fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0)), 0);

    // 0x3C with bad stop bit
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    check("ferr_pulse", 32'(frame_err), 1);
    check("ferr_no_valid", 32'(rx_valid), 0);
    gap(3);
    check("ferr_single", 32'(fe_cnt - fe0), 1);
    check("ferr_no_valid2", 32'(rx_valid), 0);

    // overrun: 0x11 held, 0x22 dropped
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    gap(2);
    check("ovr_first_valid", 32'(rx_valid), 1);
    ov0 = ov_cnt;
    send_frame(8'h22, 1'b1);
    check("ovr_pulse", 32'(overrun), 1);
    check("ovr_data_kept", 32'(rx_data), 32'h11);
    gap(3);
    check("ovr_single", 32'(ov_cnt - ov0), 1);
    check("ovr_still_valid", 32'(rx_valid), 1);
    check("ovr_data_kept2", 32'(rx_data), 32'h11);
    rx_ready = 1'b1;
    step();
    check("ovr_drained", 32'(rx_valid), 0);
    gap(2);

    // delivery on the same edge as acceptance of the held byte
    rx_ready = 1'b0;
    exp_q.push_back(8'h33);
    send_frame(8'h33, 1'b1);
    gap(2);
    exp_q.push_back(8'h44);
    send_head(8'h44);
`ifdef UART_RX_PARITY_EN
    send_bit(^8'h44 ^ PAR_ODD);
    gap(2);
`endif
    ov0 = ov_cnt;
    rx_ready = 1'b1;
    send_bit(1'b1);
    check("same_edge_valid", 32'(rx_valid), 1);
    check("same_edge_data", 32'(rx_data), 32'h44);
    gap(2);
    check("same_edge_no_ovr", 32'(ov_cnt - ov0), 0);
    check("same_edge_drained", 32'(rx_valid), 0);

    // start_flag ignored mid-frame
    exp_q.push_back(8'h5A);
    pulse_start();
    send_bit(1'b0);
    pulse_start();
    check("midstart_state", 32'(dbg_state), 32'(ST_DATA));
    gap(1);
    send_data_bits(8'h5A);
`ifdef UART_RX_PARITY_EN
    send_bit(^8'h5A ^ PAR_ODD);
    gap(2);
`endif
    send_bit(1'b1);
    check("midstart_data", 32'(rx_data), 32'h5A);
    gap(2);

    // reset mid-frame
    fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
    pulse_start();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("midrst_bps", 32'(bps_en), 0);
    gap(3);
    check("midrst_no_errs", 32'((fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0)), 0);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    check("postrst_data", 32'(rx_data), 32'hC3);
    gap(2);

    // random bytes
    for (int k = 0; k < 4; k++) begin
      rd = DW'($urandom_range(0, (1 << DW) - 1));
      exp_q.push_back(rd);
      send_frame(rd, 1'b1);
      check("rand_valid", 32'(rx_valid), 1);
      gap(2);
    end

`ifdef UART_RX_PARITY_EN
    // even parity: 0x07 has three ones so the correct parity bit is 1
    pe0 = pe_cnt;
    send_head(8'h07);
    send_bit(1'b0);
    gap(2);
    send_bit(1'b1);
    check("par_bad_pulse", 32'(parity_err), 1);
    check("par_bad_no_valid", 32'(rx_valid), 0);
    gap(3);
    check("par_bad_single", 32'(pe_cnt - pe0), 1);
    exp_q.push_back(8'h07);
    send_head(8'h07);
    send_bit(1'b1);
    gap(2);
    send_bit(1'b1);
    check("par_ok_valid", 32'(rx_valid), 1);
    check("par_ok_data", 32'(rx_data), 32'h07);
    gap(2);
`endif

    // timeout after 3 data bits
    fe0 = fe_cnt;
    pulse_start();
    send_bit(1'b0);
    gap(2);
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b1);
      if (i < 2) gap(2);
    end
    gap(TMO - 10);
    check("tmo_not_early_bps", 32'(bps_en), 1);
    check("tmo_not_early_ferr", 32'(fe_cnt - fe0), 0);
    fired = 1'b0;
    for (int i = 0; i < 20 && !fired; i++) begin
      step();
      if (frame_err) fired = 1'b1;
    end
    check("tmo_fired", 32'(fired), 1);
    check("tmo_state", 32'(dbg_state), 32'(ST_IDLE));
    check("tmo_bps", 32'(bps_en), 0);
    gap(2);
    check("tmo_single", 32'(fe_cnt - fe0), 1);
    check("tmo_no_valid", 32'(rx_valid), 0);

    gap(3);
    check("sb_queue_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
